alu_pipe: RTL and testbench
===========================

ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, datapath width in bits (WIDTH >= 4, power of two).
REQ-002 The block SHALL have port clk  input  1  single rising-edge clock.
REQ-003 The block SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-004 The block SHALL have port in_valid  input  1  operation present on opcode/a/b.
REQ-005 The block SHALL have port in_ready  output  1  block accepts an operation this cycle.
REQ-006 The block SHALL have port opcode  input  5  operation select.
REQ-007 The block SHALL have ports a, b  input  WIDTH  operands.
REQ-008 The block SHALL have port out_valid  output  1  result/flags valid.
REQ-009 The block SHALL have port out_ready  input  1  consumer takes the result.
REQ-010 The block SHALL have port result  output  WIDTH  registered result.
REQ-011 The block SHALL have port flags  output  5  registered flags {Z,C,F,L,N} (bit 4 down to bit 0).
REQ-012 The block SHALL have port psr  output  5  persistent flag register, same bit layout.

Function
REQ-013 An operation SHALL be accepted on a rising edge where in_valid && in_ready.
REQ-014 in_ready SHALL be (!out_valid || out_ready) && state == IDLE.
REQ-015 The state machine SHALL have states IDLE and MUL_RUN; all non-MUL operations complete in IDLE.
REQ-016 A non-MUL operation SHALL load result/flags and set out_valid on the accept edge (latency 1 cycle).
REQ-017 out_valid SHALL clear on an edge with out_ready && !(new load); result/flags SHALL hold stable while out_valid && !out_ready.
REQ-018 psr SHALL load the new flags on the same edge that loads result, except for NOP and illegal opcodes (psr unchanged).
REQ-019 Opcodes: ADD 00000, ADDU 00010, ADDC 00100, SUB 01000, CMP 01010, AND 01100, OR 01101, XOR 01110, NOT 01111 (~a), LSH 10000, RSH 10010, ARSH 10101, NOP 10110, MUL 11000; all others illegal.
REQ-020 ADD/SUB: WIDTH-bit wrap; F = signed overflow; C = 0.
REQ-021 ADDU: C = carry-out of a+b; F = 0. ADDC: a+b+psr.C, C = carry-out, F = signed overflow.
REQ-022 CMP: result 0; L = (a < b unsigned); N = (a < b signed); Z = (a == b).
REQ-023 Shifts SHALL use amount b[log2(WIDTH)-1:0]; ARSH replicates a[WIDTH-1]; C = last bit shifted out (0 for amount 0).
REQ-024 Z SHALL be (result == 0) for all ops except CMP and illegal; flags not defined for an op SHALL be 0.
REQ-025 Illegal opcode and NOP SHALL produce result 0, flags 0 with latency 1.
REQ-026 Accepting a MUL SHALL enter MUL_RUN for WIDTH cycles (shift-add, one bit per cycle), then load result = low WIDTH bits of a*b (unsigned), C = (high WIDTH bits != 0), Z per REQ-024, out_valid = 1, return to IDLE; total latency WIDTH+1 cycles.
REQ-027 Operands for MUL SHALL be captured at accept; later changes to a/b SHALL NOT affect the product.

Reset
REQ-028 Asserting reset_n low SHALL immediately clear out_valid, result, flags, psr to 0 and force IDLE, including mid-MUL (partial product discarded).
REQ-029 in_ready SHALL be 1 in the first cycle after reset_n deasserts.

Configuration
REQ-030 Macro ALU_PIPE_MUL_EN defined: MUL per REQ-026/027. Undefined: no MUL_RUN state or multiplier logic; opcode 11000 treated as illegal per REQ-025.

Verification (WIDTH=16)
REQ-031 ADD a=0x7FFF b=0x0001 -> next cycle result 0x8000, F=1, Z=0, C=0, out_valid=1.
REQ-032 ADDU 0xFFFF+0x0001 -> result 0x0000, Z=1, C=1, psr.C=1; then ADDC a=0x0005 b=0x0000 -> result 0x0006, C=0.
REQ-033 CMP a=0xFFFE b=0x0001 -> result 0, L=0, N=1, Z=0; CMP a=b=0x1234 -> Z=1, L=0, N=0.
REQ-034 out_ready=0 for 3 cycles after an AND result -> result/flags held, in_ready=0, pending in_valid not accepted until out_ready=1.
REQ-035 With ALU_PIPE_MUL_EN: MUL 0x0012*0x0034 -> in_ready=0 for 16 cycles, out_valid on cycle 17, result 0x03A8, C=0; MUL 0x0100*0x0100 -> result 0x0000, C=1, Z=1; reset_n low at cycle 8 of a MUL -> out_valid=0, psr=0, in_ready=1 after release.
REQ-036 Without ALU_PIPE_MUL_EN: MUL 0x0012*0x0034 -> next cycle result 0x0000, flags 0, psr unchanged.

Source files
------------

// File: rtl/alu_pipe.sv
// alu_pipe: single-issue ALU with a registered result/flag stage, a
// persistent flag register (psr) and an optional iterative multiplier.
// Build option: define ALU_PIPE_MUL_EN to include the MUL opcode and the
// MUL_RUN state; without it opcode 11000 behaves like any illegal opcode.
// Handshake: an operation transfers on a rising edge where in_valid && in_ready;
// a result transfers on a rising edge where out_valid && out_ready, and
// result/flags stay stable while out_valid && !out_ready.
// Flag layout (result flags and psr): {Z, C, F, L, N}, bit 4 down to bit 0.
// dbg_state exposes the FSM state (0 = IDLE, 1 = MUL_RUN).
module alu_pipe #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [4:0]       flags,
    output logic [4:0]       psr,
    output logic             dbg_state
);

    localparam int SHW = $clog2(WIDTH);
    localparam int MSB = WIDTH - 1;

    // Flag bit positions.
    localparam int FZ = 4;
    localparam int FC = 3;
    localparam int FF = 2;
    localparam int FL = 1;
    localparam int FN = 0;

    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_ADDU = 5'b00010;
    localparam logic [4:0] OP_ADDC = 5'b00100;
    localparam logic [4:0] OP_SUB  = 5'b01000;
    localparam logic [4:0] OP_CMP  = 5'b01010;
    localparam logic [4:0] OP_AND  = 5'b01100;
    localparam logic [4:0] OP_OR   = 5'b01101;
    localparam logic [4:0] OP_XOR  = 5'b01110;
    localparam logic [4:0] OP_NOT  = 5'b01111;
    localparam logic [4:0] OP_LSH  = 5'b10000;
    localparam logic [4:0] OP_RSH  = 5'b10010;
    localparam logic [4:0] OP_ARSH = 5'b10101;
    localparam logic [4:0] OP_NOP  = 5'b10110;

`ifdef ALU_PIPE_MUL_EN
    localparam logic [4:0] OP_MUL  = 5'b11000;
    localparam int         CNT_W   = $clog2(WIDTH);

    typedef enum logic {
        IDLE    = 1'b0,
        MUL_RUN = 1'b1
    } state_e;
`else
    typedef enum logic {
        IDLE = 1'b0
    } state_e;
`endif

    state_e           state_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] result_q;
    logic [4:0]       flags_q;
    logic [4:0]       psr_q;

    logic [WIDTH-1:0] res_d;
    logic [4:0]       flg_d;
    logic             psr_we_d;
    logic             z_en;
    logic             is_mul_d;
    logic             accept;
    logic [SHW-1:0]   sh_amt;

    assign in_ready  = (!out_valid_q || out_ready) && (state_q == IDLE);
    assign accept    = in_valid && in_ready;
    assign sh_amt    = b[SHW-1:0];

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign flags     = flags_q;
    assign psr       = psr_q;
    assign dbg_state = (state_q != IDLE);

`ifdef ALU_PIPE_MUL_EN
    assign is_mul_d = (opcode == OP_MUL);
`else
    assign is_mul_d = 1'b0;
`endif

    // Single-cycle ALU: result and flags for every non-MUL opcode.
    always_comb begin
        res_d    = '0;
        flg_d    = '0;
        psr_we_d = 1'b1;
        z_en     = 1'b1;
        case (opcode)
            OP_ADD: begin
                res_d     = a + b;
                flg_d[FF] = (a[MSB] == b[MSB]) && (res_d[MSB] != a[MSB]);
            end
            OP_ADDU: begin
                {flg_d[FC], res_d} = {1'b0, a} + {1'b0, b};
            end
            OP_ADDC: begin
                {flg_d[FC], res_d} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, psr_q[FC]};
                flg_d[FF] = (a[MSB] == b[MSB]) && (res_d[MSB] != a[MSB]);
            end
            OP_SUB: begin
                res_d     = a - b;
                flg_d[FF] = (a[MSB] != b[MSB]) && (res_d[MSB] != a[MSB]);
            end
            OP_CMP: begin
                z_en      = 1'b0;
                flg_d[FZ] = (a == b);
                flg_d[FL] = (a < b);
                flg_d[FN] = ($signed(a) < $signed(b));
            end
            OP_AND: res_d = a & b;
            OP_OR:  res_d = a | b;
            OP_XOR: res_d = a ^ b;
            OP_NOT: res_d = ~a;
            // The extra bit on the outgoing side catches the last bit shifted out.
            OP_LSH: begin
                {flg_d[FC], res_d} = {1'b0, a} << sh_amt;
            end
            OP_RSH: begin
                {res_d, flg_d[FC]} = {a, 1'b0} >> sh_amt;
            end
            OP_ARSH: begin
                {res_d, flg_d[FC]} = $signed({a, 1'b0}) >>> sh_amt;
            end
            OP_NOP: begin
                psr_we_d = 1'b0;
                z_en     = 1'b0;
            end
            default: begin
                psr_we_d = 1'b0;
                z_en     = 1'b0;
            end
        endcase
        if (z_en) begin
            flg_d[FZ] = (res_d == '0);
        end
    end

`ifdef ALU_PIPE_MUL_EN
    // Multiplier datapath: prod holds {partial sum, unconsumed multiplier bits}.
    logic [WIDTH-1:0]   mcand_q;
    logic [2*WIDTH-1:0] prod_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] prod_d;
    logic [4:0]         mul_flg;

    // One shift-add step: add the multiplicand when the low multiplier bit is set, then shift right.
    always_comb begin
        mul_sum      = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
        prod_d       = {mul_sum, prod_q[WIDTH-1:1]};
        mul_flg      = '0;
        mul_flg[FZ]  = (prod_d[WIDTH-1:0] == '0);
        mul_flg[FC]  = (prod_d[2*WIDTH-1:WIDTH] != '0);
    end

    // Operand capture at accept and per-cycle iteration while in MUL_RUN.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mcand_q <= '0;
            prod_q  <= '0;
            cnt_q   <= '0;
        end else if (state_q == IDLE) begin
            if (accept && is_mul_d) begin
                mcand_q <= a;
                prod_q  <= {{WIDTH{1'b0}}, b};
                cnt_q   <= CNT_W'(WIDTH - 1);
            end
        end else begin
            prod_q <= prod_d;
            cnt_q  <= cnt_q - CNT_W'(1);
        end
    end
`endif

    // Control FSM with the registered result, flags and psr.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            flags_q     <= '0;
            psr_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept && is_mul_d) begin
`ifdef ALU_PIPE_MUL_EN
                        state_q <= MUL_RUN;
`endif
                        // Accept implies any previous result is leaving this edge.
                        out_valid_q <= 1'b0;
                    end else if (accept) begin
                        result_q    <= res_d;
                        flags_q     <= flg_d;
                        out_valid_q <= 1'b1;
                        if (psr_we_d) begin
                            psr_q <= flg_d;
                        end
                    end else if (out_ready) begin
                        out_valid_q <= 1'b0;
                    end
                end
`ifdef ALU_PIPE_MUL_EN
                MUL_RUN: begin
                    // Last step: the product is complete in prod_d this cycle.
                    if (cnt_q == '0) begin
                        state_q     <= IDLE;
                        result_q    <= prod_d[WIDTH-1:0];
                        flags_q     <= mul_flg;
                        psr_q       <= mul_flg;
                        out_valid_q <= 1'b1;
                    end
                end
`endif
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed literal cases plus randomized traffic checked every
// cycle against a behavioural model of alu_pipe (WIDTH = 16).
// Honours ALU_PIPE_MUL_EN the same way the design does.
`timescale 1ns/1ps
module tb_alu_pipe;
  localparam int     W    = 16;
  localparam longint MOD  = 64'd1 << W;
  localparam longint MAXS = (64'd1 << (W - 1)) - 1;
  localparam longint MINS = -(64'sd1 <<< (W - 1));
`ifdef ALU_PIPE_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic         clk = 1'b0;
  logic         reset_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic [4:0]   opcode = '0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         in_ready, out_valid, dbg_state;
  logic [W-1:0] result;
  logic [4:0]   flags, psr;

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(W)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flags(flags), .psr(psr), .dbg_state(dbg_state)
  );

  int n_checks = 0;
  int n_err = 0;
  int cyc = 0;
  int ready_mode = 0;  // 0: always ready, 1: random, 2: stalled

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: out_ready = 1'b1;
      2: out_ready = 1'b0;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [W-1:0] res;
    logic [4:0]   flg;
    bit           we;
    bit           mul;
    int           due;
  } exp_t;

  function automatic exp_t model(input logic [4:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                                 input bit cin);
    exp_t   e;
    longint ux, uy, sx, sy, t, s;
    int     amt;
    bit     zz, c, fo, l, n, z_ok;
    ux = longint'(x);
    uy = longint'(y);
    sx = x[W-1] ? ux - MOD : ux;
    sy = y[W-1] ? uy - MOD : uy;
    amt = int'(uy % W);
    t = 0; zz = 0; c = 0; fo = 0; l = 0; n = 0; z_ok = 1;
    e.we = 1; e.mul = 0;
    case (op)
      5'b00000: begin t = (ux + uy) % MOD; s = sx + sy; fo = (s > MAXS) || (s < MINS); end
      5'b00010: begin t = (ux + uy) % MOD; c = (ux + uy) >= MOD; end
      5'b00100: begin
        t = (ux + uy + cin) % MOD; c = (ux + uy + cin) >= MOD;
        s = sx + sy + cin; fo = (s > MAXS) || (s < MINS);
      end
      5'b01000: begin t = (ux - uy + MOD) % MOD; s = sx - sy; fo = (s > MAXS) || (s < MINS); end
      5'b01010: begin z_ok = 0; zz = (ux == uy); l = (ux < uy); n = (sx < sy); end
      5'b01100: t = ux & uy;
      5'b01101: t = ux | uy;
      5'b01110: t = ux ^ uy;
      5'b01111: t = (MOD - 1) - ux;
      5'b10000: begin t = (ux << amt) % MOD; c = (amt == 0) ? 1'b0 : 1'((ux >> (W - amt)) & 1); end
      5'b10010: begin t = ux >> amt; c = (amt == 0) ? 1'b0 : 1'((ux >> (amt - 1)) & 1); end
      5'b10101: begin t = (sx >>> amt) & (MOD - 1); c = (amt == 0) ? 1'b0 : 1'((ux >> (amt - 1)) & 1); end
      5'b11000: begin
        if (MUL_EN) begin
          e.mul = 1; t = (ux * uy) % MOD; c = ((ux * uy) / MOD) != 0;
        end else begin
          e.we = 0; z_ok = 0;
        end
      end
      default: begin e.we = 0; z_ok = 0; end
    endcase
    if (z_ok) zz = (t == 0);
    e.res = t[W-1:0];
    e.flg = {zz, c, fo, l, n};
    e.due = 0;
    return e;
  endfunction

  // ---------------- scoreboard / compare process ----------------
  exp_t       exp_q[$];
  logic [4:0] vis_psr = '0;

  always @(negedge clk) begin : cmp_proc
    exp_t h;
    exp_t nw;
    bit   e_ov, e_busy, e_rdy;
    cyc++;
    if (!reset_n) begin
      exp_q.delete();
      vis_psr = '0;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_result", result, 0);
      chk("rst_flags", flags, 0);
      chk("rst_psr", psr, 0);
    end else begin
      if (exp_q.size() > 0 && exp_q[0].due == cyc && exp_q[0].we) vis_psr = exp_q[0].flg;
      e_ov   = (exp_q.size() > 0) && (exp_q[0].due <= cyc);
      e_busy = (exp_q.size() > 0) && (exp_q[0].due > cyc);
      e_rdy  = (!e_ov || out_ready) && !e_busy;
      chk("out_valid", out_valid, e_ov);
      chk("in_ready", in_ready, e_rdy);
      chk("psr", psr, vis_psr);
      chk("dbg_state", dbg_state, e_busy);
      if (e_ov) begin
        h = exp_q[0];
        chk("result", result, h.res);
        chk("flags", flags, h.flg);
      end
      if (e_ov && out_ready) void'(exp_q.pop_front());
      if (e_rdy && in_valid) begin
        nw = model(opcode, a, b, vis_psr[3]);
        nw.due = cyc + 1 + (nw.mul ? W : 0);
        exp_q.push_back(nw);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called just after a rising edge; returns just after the accepting edge.
  task automatic drive_op(input logic [4:0] op, input logic [W-1:0] av, input logic [W-1:0] bv);
    bit done = 0;
    in_valid = 1'b1; opcode = op; a = av; b = bv;
    for (int t = 0; t < 100 && !done; t++) begin
      @(negedge clk);
      if (in_ready === 1'b1) done = 1;
    end
    if (!done) begin
      n_checks++; n_err++;
      $display("FAIL accept_timeout: in_ready never 1 for op %b (cycle %0d)", op, cyc);
    end
    @(posedge clk); #2;
    in_valid = 1'b0; a = W'($urandom); b = W'($urandom); opcode = 5'($urandom);
  endtask

  task automatic do_op(input string nm, input logic [4:0] op, input logic [W-1:0] av,
                       input logic [W-1:0] bv, input logic [W-1:0] er, input logic [4:0] ef,
                       input logic [4:0] ep);
    drive_op(op, av, bv);
    @(negedge clk);
    chk({nm, "_valid"}, out_valid, 1);
    chk({nm, "_res"}, result, er);
    chk({nm, "_flags"}, flags, ef);
    chk({nm, "_psr"}, psr, ep);
    @(posedge clk); #2;
  endtask

`ifdef ALU_PIPE_MUL_EN
  task automatic do_mul(input string nm, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic [W-1:0] er, input logic [4:0] ef);
    drive_op(5'b11000, av, bv);
    for (int k = 1; k <= W; k++) begin
      @(negedge clk);
      chk({nm, "_busy_ready"}, in_ready, 0);
    end
    @(negedge clk);
    chk({nm, "_valid"}, out_valid, 1);
    chk({nm, "_res"}, result, er);
    chk({nm, "_flags"}, flags, ef);
    chk({nm, "_psr"}, psr, ef);
    @(posedge clk); #2;
  endtask
`endif

  // Waits wait_cycles edges, then pulses reset between edges.
  task automatic reset_pulse(input string nm, input int wait_cycles);
    repeat (wait_cycles) @(posedge clk);
    #2; reset_n = 1'b0; #1;
    chk({nm, "_valid"}, out_valid, 0);
    chk({nm, "_res"}, result, 0);
    chk({nm, "_flags"}, flags, 0);
    chk({nm, "_psr"}, psr, 0);
    repeat (2) @(posedge clk);
    #2; reset_n = 1'b1;
    @(negedge clk);
    chk({nm, "_ready_after"}, in_ready, 1);
    @(posedge clk); #2;
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 4))
      0: return '0;
      1: return '1;
      2: return W'(16'h8000);
      default: return W'($urandom);
    endcase
  endfunction

  logic [4:0] ops_tbl [14] = '{5'b00000, 5'b00010, 5'b00100, 5'b01000, 5'b01010, 5'b01100, 5'b01101,
                               5'b01110, 5'b01111, 5'b10000, 5'b10010, 5'b10101, 5'b10110, 5'b11000};

  // ---------------- main sequence ----------------
  initial begin
    #1 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk);
    chk("post_reset_ready", in_ready, 1);
    @(posedge clk); #2;

    do_op("add_ovf",  5'b00000, 16'h7FFF, 16'h0001, 16'h8000, 5'b00100, 5'b00100);
    do_op("addu_cy",  5'b00010, 16'hFFFF, 16'h0001, 16'h0000, 5'b11000, 5'b11000);
    do_op("addc",     5'b00100, 16'h0005, 16'h0000, 16'h0006, 5'b00000, 5'b00000);
    do_op("cmp_neg",  5'b01010, 16'hFFFE, 16'h0001, 16'h0000, 5'b00001, 5'b00001);
    do_op("cmp_eq",   5'b01010, 16'h1234, 16'h1234, 16'h0000, 5'b10000, 5'b10000);
    do_op("lsh_c",    5'b10000, 16'h8001, 16'h0001, 16'h0002, 5'b01000, 5'b01000);
    do_op("rsh_c",    5'b10010, 16'h0003, 16'h0001, 16'h0001, 5'b01000, 5'b01000);
    do_op("arsh15",   5'b10101, 16'h8000, 16'h000F, 16'hFFFF, 5'b00000, 5'b00000);
    do_op("lsh_amt0", 5'b10000, 16'h8000, 16'h0010, 16'h8000, 5'b00000, 5'b00000);
    do_op("not",      5'b01111, 16'hFFFF, 16'h0000, 16'h0000, 5'b10000, 5'b10000);
    do_op("sub_ovf",  5'b01000, 16'h8000, 16'h0001, 16'h7FFF, 5'b00100, 5'b00100);
    do_op("nop",      5'b10110, 16'h1111, 16'h2222, 16'h0000, 5'b00000, 5'b00100);
    do_op("illegal",  5'b11111, 16'h1111, 16'h2222, 16'h0000, 5'b00000, 5'b00100);
`ifndef ALU_PIPE_MUL_EN
    do_op("mul_off",  5'b11000, 16'h0012, 16'h0034, 16'h0000, 5'b00000, 5'b00100);
`endif

    // Back-pressure: AND result held while a pending OR waits.
    ready_mode = 2;
    drive_op(5'b01100, 16'h0F0F, 16'h00FF);
    in_valid = 1'b1; opcode = 5'b01101; a = 16'h00F0; b = 16'h0F00;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("hold_valid", out_valid, 1);
      chk("hold_res", result, 16'h000F);
      chk("hold_flags", flags, 0);
      chk("hold_ready", in_ready, 0);
    end
    ready_mode = 0;
    @(posedge clk); #2;
    do_op("or_after", 5'b01101, 16'h00F0, 16'h0F00, 16'h0FF0, 5'b00000, 5'b00000);

`ifdef ALU_PIPE_MUL_EN
    do_mul("mul_small", 16'h0012, 16'h0034, 16'h03A8, 5'b00000);
    do_mul("mul_hi",    16'h0100, 16'h0100, 16'h0000, 5'b11000);
    drive_op(5'b11000, 16'h0012, 16'h0034);
    reset_pulse("rst_mid_mul", 7);
    repeat (W + 4) begin @(posedge clk); #2; end
`endif

    // Reset while a result is waiting and psr is non-zero.
    ready_mode = 2;
    drive_op(5'b00010, 16'hFFFF, 16'h0001);
    @(negedge clk);
    chk("pre_rst_psr", psr, 5'b11000);
    @(posedge clk); #2;
    reset_pulse("rst_pending", 0);
    ready_mode = 0;

    // Randomized traffic with random back-pressure and gaps.
    ready_mode = 1;
    for (int i = 0; i < 400; i++) begin
      int         r;
      logic [4:0] op;
      r  = $urandom_range(0, 17);
      op = (r < 14) ? ops_tbl[r] : 5'($urandom_range(0, 31));
      drive_op(op, pick(), pick());
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #2; end
    end

    ready_mode = 0;
    for (int t = 0; t < 60 && exp_q.size() > 0; t++) @(posedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d results still outstanding, expected 0", exp_q.size());
    end
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    n_err++;
    $display("FAIL watchdog: simulation did not finish, cycle %0d expected below 200000", cyc);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $fatal(1, "watchdog expired");
  end
endmodule
